// File: rtl/mem_access_master.sv
// ============================================================================
// mem_access_master: load/store initiator for a word-wide, byte-enable-free
// data memory. Sub-word stores are read-modify-write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_master #(
  parameter int ADDR_WIDTH      = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out,
  output logic                  mem_we
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  offset;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        write;

  logic        illegal;
  logic        misaligned;
  logic [1:0]  eff_off;

  assign req_ready = (state == IDLE);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    eff_off    = req_addr[1:0];
    if (req_write) illegal = (req_funct3 > 3'd2);
    else           illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // Without error reporting, misaligned accesses are pulled down to their natural boundary.
    if (!ERR_ON_MISALIGN) begin
      if (req_funct3[1:0] == 2'b01)      eff_off[0] = 1'b0;
      else if (req_funct3[1:0] == 2'b10) eff_off    = 2'b00;
    end
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] m;
    m = w;
    if (f3[1:0] == 2'b00) begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (f3[1:0] == 2'b01) begin
      if (off[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= 32'd0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_error  <= 1'b0;
      offset      <= 2'd0;
      funct3      <= 3'd0;
      wdata       <= 32'd0;
      write       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            offset <= eff_off;
            funct3 <= req_funct3;
            wdata  <= req_wdata;
            write  <= req_write;
            if (illegal || (misaligned && ERR_ON_MISALIGN)) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= ERR;
            end else begin
              mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_write && (req_funct3 == 3'd2)) begin
                mem_data_in <= req_wdata;
                mem_we      <= 1'b1;
                state       <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          // Stores reaching READ are sub-word: merge into the fetched word.
          if (write) begin
            mem_data_in <= merge(mem_data_out, wdata, offset, funct3);
            mem_we      <= 1'b1;
            state       <= WRITE;
          end else begin
            resp_rdata <= extract(mem_data_out, offset, funct3);
            resp_error <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 32'd0;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_master.sv
// ============================================================================
// tb_mem_access_master: directed checks of mem_access_master against two
// behavioural memories, one DUT per misalignment policy.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        req_ready_a, resp_valid_a, resp_error_a, mem_we_a;
  logic [31:0] resp_rdata_a, mem_address_a, mem_data_in_a, mem_data_out_a;
  logic        req_ready_b, resp_valid_b, resp_error_b, mem_we_b;
  logic [31:0] resp_rdata_b, mem_address_b, mem_data_in_b, mem_data_out_b;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  int vectors = 0;
  int miscompares = 0;

  int          resp_cycle, resp_count, we_cycle, we_count;
  logic [31:0] resp_rd;
  logic        resp_err;
  logic [31:0] o_addr [1:5];
  logic [31:0] o_din  [1:5];

  always #5 clk = ~clk;

  mem_access_master #(.ADDR_WIDTH(32), .ERR_ON_MISALIGN(1'b1)) dut (
    .clock(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_error(resp_error_a),
    .mem_address(mem_address_a), .mem_data_in(mem_data_in_a),
    .mem_data_out(mem_data_out_a), .mem_we(mem_we_a));

  mem_access_master #(.ADDR_WIDTH(32), .ERR_ON_MISALIGN(1'b0)) dut_nomis (
    .clock(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_error(resp_error_b),
    .mem_address(mem_address_b), .mem_data_in(mem_data_in_b),
    .mem_data_out(mem_data_out_b), .mem_we(mem_we_b));

  assign mem_data_out_a = mem_a[mem_address_a[7:2]];
  assign mem_data_out_b = mem_b[mem_address_b[7:2]];

  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_address_a[7:2]] <= mem_data_in_a;
    if (mem_we_b) mem_b[mem_address_b[7:2]] <= mem_data_in_b;
  end

  // Issue one request to the selected DUT and record five cycles after acceptance.
  task automatic issue(input bit use_b, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic rv, we;
    @(negedge clk);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (use_b) req_valid_b = 1'b1;
    else       req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    resp_cycle = 0; resp_count = 0; we_cycle = 0; we_count = 0;
    resp_rd = 32'hxxxxxxxx; resp_err = 1'bx;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rv        = use_b ? resp_valid_b  : resp_valid_a;
      we        = use_b ? mem_we_b      : mem_we_a;
      o_addr[k] = use_b ? mem_address_b : mem_address_a;
      o_din[k]  = use_b ? mem_data_in_b : mem_data_in_a;
      if (rv) begin
        resp_count++;
        if (resp_cycle == 0) begin
          resp_cycle = k;
          resp_rd  = use_b ? resp_rdata_b : resp_rdata_a;
          resp_err = use_b ? resp_error_b : resp_error_a;
        end
      end
      if (we) begin
        we_count++;
        we_cycle = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready_a, mem_we_a, resp_valid_a, resp_error_a} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy/we/rv/err=%b exp 1000",
               {req_ready_a, mem_we_a, resp_valid_a, resp_error_a});
    end
    vectors++;
    if ({mem_address_a, mem_data_in_a, resp_rdata_a} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h din=%h rdata=%h exp all 0",
               mem_address_a, mem_data_in_a, resp_rdata_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [0:4] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] ad  [0:4] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exp [0:4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899,
                               32'h0000AABB, 32'h8899AABB};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b0, f3[i], ad[i], 32'd0);
      vectors++;
      if (resp_cycle != 2 || resp_count != 1) begin
        miscompares++;
        $display("FAIL load%0d_latency: got cycle %0d count %0d exp cycle 2 count 1",
                 i, resp_cycle, resp_count);
      end
      vectors++;
      if (resp_rd !== exp[i] || resp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL load%0d_rdata: got %h err %b exp %h err 0", i, resp_rd, resp_err, exp[i]);
      end
      vectors++;
      if (we_count != 0 || o_addr[1] !== 32'h10) begin
        miscompares++;
        $display("FAIL load%0d_mem: got we_count %0d addr %h exp 0 and 00000010",
                 i, we_count, o_addr[1]);
      end
    end
  endtask

  task automatic test_sub_store();
    issue(1'b0, 1'b1, 3'd0, 32'h11, 32'h12345677);
    vectors++;
    if (we_count != 1 || we_cycle != 2 || o_din[2] !== 32'h889977BB) begin
      miscompares++;
      $display("FAIL sb_write: got we_count %0d at %0d din %h exp 1 at 2 din 889977bb",
               we_count, we_cycle, o_din[2]);
    end
    vectors++;
    if (resp_cycle != 3 || resp_count != 1 || resp_rd !== 32'd0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_resp: got cycle %0d count %0d rdata %h err %b exp 3 1 0 0",
               resp_cycle, resp_count, resp_rd, resp_err);
    end
    vectors++;
    if (o_addr[3] !== 32'h10 || o_din[3] !== 32'h889977BB) begin
      miscompares++;
      $display("FAIL sb_hold: got addr %h din %h in resp cycle exp 00000010 889977bb",
               o_addr[3], o_din[3]);
    end
    issue(1'b0, 1'b0, 3'd2, 32'h10, 32'd0);
    vectors++;
    if (resp_rd !== 32'h889977BB) begin
      miscompares++;
      $display("FAIL sb_readback: got %h exp 889977bb", resp_rd);
    end
    issue(1'b0, 1'b1, 3'd1, 32'h12, 32'h0000CAFE);
    vectors++;
    if (we_cycle != 2 || o_din[2] !== 32'hCAFE77BB || resp_cycle != 3) begin
      miscompares++;
      $display("FAIL sh_write: got we at %0d din %h resp at %0d exp 2 cafe77bb 3",
               we_cycle, o_din[2], resp_cycle);
    end
  endtask

  task automatic test_word_store();
    issue(1'b0, 1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
    vectors++;
    if (we_count != 1 || we_cycle != 1 || o_din[1] !== 32'hDEADBEEF || o_addr[1] !== 32'h20) begin
      miscompares++;
      $display("FAIL sw_write: got we_count %0d at %0d din %h addr %h exp 1 at 1 deadbeef 00000020",
               we_count, we_cycle, o_din[1], o_addr[1]);
    end
    vectors++;
    if (resp_cycle != 2 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_resp: got cycle %0d err %b exp 2 0", resp_cycle, resp_err);
    end
    issue(1'b0, 1'b0, 3'd2, 32'h20, 32'd0);
    vectors++;
    if (resp_rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_readback: got %h exp deadbeef", resp_rd);
    end
  endtask

  task automatic test_misalign();
    logic        wr [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [0:3] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [31:0] ad [0:3] = '{32'h22, 32'h21, 32'h10, 32'h10};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, wr[i], f3[i], ad[i], 32'h0000BEEF);
      vectors++;
      if (resp_cycle != 1 || resp_err !== 1'b1 || resp_rd !== 32'd0) begin
        miscompares++;
        $display("FAIL err%0d_resp: got cycle %0d err %b rdata %h exp 1 1 0",
                 i, resp_cycle, resp_err, resp_rd);
      end
      vectors++;
      if (we_count != 0 || o_addr[1] !== 32'h20) begin
        miscompares++;
        $display("FAIL err%0d_mem: got we_count %0d addr %h exp 0 00000020",
                 i, we_count, o_addr[1]);
      end
    end
    mem_b[8] = 32'h11223344;
    issue(1'b1, 1'b0, 3'd2, 32'h22, 32'd0);
    vectors++;
    if (resp_cycle != 2 || resp_err !== 1'b0 || resp_rd !== 32'h11223344 || o_addr[1] !== 32'h20) begin
      miscompares++;
      $display("FAIL nomis_lw: got cycle %0d err %b rdata %h addr %h exp 2 0 11223344 00000020",
               resp_cycle, resp_err, resp_rd, o_addr[1]);
    end
    issue(1'b1, 1'b1, 3'd1, 32'h21, 32'h0000BEEF);
    vectors++;
    if (we_cycle != 2 || o_din[2] !== 32'h1122BEEF || resp_cycle != 3 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL nomis_sh: got we at %0d din %h resp at %0d err %b exp 2 1122beef 3 0",
               we_cycle, o_din[2], resp_cycle, resp_err);
    end
  endtask

  task automatic test_reset_mid();
    int rv_seen = 0;
    int we_seen = 0;
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h00001111;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_we_a !== 1'b0 || resp_valid_a !== 1'b0 || req_ready_a !== 1'b1 ||
        mem_a[4] !== 32'hCAFE77BB) begin
      miscompares++;
      $display("FAIL rst_mid: got we %b rv %b rdy %b word %h exp 0 0 1 cafe77bb",
               mem_we_a, resp_valid_a, req_ready_a, mem_a[4]);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid_a) rv_seen++;
      if (mem_we_a)     we_seen++;
    end
    vectors++;
    if (rv_seen != 0 || we_seen != 0 || mem_a[4] !== 32'hCAFE77BB) begin
      miscompares++;
      $display("FAIL rst_mid_after: got rv %0d we %0d word %h exp 0 0 cafe77bb",
               rv_seen, we_seen, mem_a[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  rdy_pat = '0;
    logic [8:0]  rv_pat  = '0;
    logic        rd_ok   = 1'b1;
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    req_valid_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rdy_pat[i] = req_ready_a;
      rv_pat[i]  = resp_valid_a;
      if (resp_valid_a && resp_rdata_a !== 32'hCAFE77BB) rd_ok = 1'b0;
      @(negedge clk);
    end
    req_valid_a = 1'b0;
    vectors++;
    if (rdy_pat !== 9'b001001001) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b exp 001001001", rdy_pat);
    end
    vectors++;
    if (rv_pat !== 9'b100100100 || rd_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_resp: got %b rdata_ok %b exp 100100100 1", rv_pat, rd_ok);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    mem_a[4] = 32'h8899AABB;
    test_reset();
    test_loads();
    test_sub_store();
    test_word_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator side of the word-wide data memory port: the processor's load/store path issues byte, halfword and word requests, and this block drives the memory's address, data_in and we signals and collects data_out.
- The memory is word-addressed, has a combinational read and writes whenever we is high; there are no byte enables.
- Sub-word stores are therefore done as read-modify-write.
- Sub-word loads are lane-extracted and sign- or zero-extended (RISC-V funct3 encoding, little-endian).

Parameters:
- ADDR_WIDTH, 32, width of request and memory address.
- ERR_ON_MISALIGN, 1, 1 = misaligned request returns an error with no memory access; 0 = the low offset bits that cause misalignment are forced to zero and the access proceeds.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH
- resp_valid  output  1  one-cycle completion pulse, no backpressure
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned or illegal funct3; valid with resp_valid
- mem_address  output  ADDR_WIDTH  registered, always word-aligned ({addr[ADDR_WIDTH-1:2],2'b00})
- mem_data_in  output  32  registered write data
- mem_data_out  input  32  combinational read data for mem_address
- mem_we  output  1  registered write enable

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE.
  - Cleared to 0: mem_we, mem_address, mem_data_in, resp_valid, resp_rdata, resp_error.
  - A request in flight is dropped with no response. A write already completed before reset is not undone.
- States: IDLE, READ, WRITE, RESP, ERR.
- IDLE: req_ready=1; on acceptance, latch addr, funct3, wdata and write.
  - Illegal funct3 (load 3/6/7; store >2) or misaligned access (H with addr[0]=1; W with addr[1:0]!=0, ERR_ON_MISALIGN=1) goes to ERR.
  - SW goes to WRITE. In the same edge, load mem_address and mem_data_in=wdata, and set mem_we=1.
  - Loads, SB and SH go to READ. In the same edge, load mem_address; mem_we stays 0.
- READ (one cycle): mem_data_out is valid at the end of the cycle and is captured on the edge.
  - Load: go to RESP with resp_rdata extracted from byte lane addr[1:0] or halfword lane addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - SB/SH: merge the low byte/halfword of wdata into the captured word at the addressed lane. Set mem_data_in=merged and mem_we=1, then go to WRITE.
- WRITE: mem_we is high for exactly this one cycle; mem_address and mem_data_in are stable throughout. Next state is RESP with mem_we=0.
- RESP: resp_valid=1 for one cycle, resp_error=0; then IDLE.
  - mem_address and mem_data_in are held unchanged during RESP, so they never change on the edge where mem_we falls.
- ERR: resp_valid=1 and resp_error=1, resp_rdata=0, no memory activity; then IDLE.
- Outside response cycles, resp_valid=0 and resp_rdata and resp_error hold their last values.
- Latency (accept edge = T):
  - Loads: resp at T+2.
  - SW: we at T+1, resp at T+2.
  - SB/SH: read at T+1, we at T+2, resp at T+3.
  - Error: resp at T+1.
- req_valid outside IDLE is ignored; there is no queueing.
- mem_we is never high in IDLE, READ, RESP or ERR.
- Address bits above bit 1 pass through unmodified; no bounds check against memory size.

Test Plan:
- Word at 0x10 preloaded to 0x8899AABB. LB 0x13 -> rdata 0xFFFFFF88 at T+2; LBU 0x13 -> 0x00000088; mem_we 0 throughout.
- Same word. LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB; LW 0x10 -> 0x8899AABB.
- SB 0x11 with wdata 0x12345677:
  - mem_we is 1 for exactly one cycle at T+2, with mem_data_in 0x889977BB; resp at T+3.
  - A following LW 0x10 returns 0x889977BB.
- SW 0x20 with 0xDEADBEEF -> mem_we at T+1 only, resp at T+2; LW 0x20 returns 0xDEADBEEF.
- LW 0x22 and SH 0x21:
  - ERR_ON_MISALIGN=1: resp_error=1 at T+1, rdata 0, mem_we never set, mem_address unchanged.
  - ERR_ON_MISALIGN=0: accesses go to 0x20, resp_error 0.
- Reset asserted during the READ cycle of SH 0x10:
  - Next edge: mem_we 0, no resp_valid, word at 0x10 unchanged, req_ready 1.
  - Back-to-back requests with req_valid held high are accepted only in IDLE.
